return_stack: RTL and testbench

- Hardware call/return address stack for the 9-bit CPU. It is the producer of the program counter's `rl` (return link) input.
- On every subroutine call it captures the return address, `rp + 1`. On every return it presents that address on `rl` and pops it.
- Sits beside the program counter and is driven by the same decoder control strobes. Shares `clk` and `start` with the program counter.

---
 rtl/return_stack_if.sv | 28 ++
 rtl/return_stack.sv | 73 +++++++
 tb/tb_return_stack.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/return_stack_if.sv
// Control strobes and return-link outputs shared between the decoder side and the return stack.
interface return_stack_if #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 10
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic          branch;
  logic          jump2sub;
  logic          retFsub;
  logic [AW-1:0] rp;
  logic [AW-1:0] rl;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;

  modport master (
    output branch, jump2sub, retFsub, rp,
    input  rl, empty, full, count, overflow, underflow
  );

  modport slave (
    input  branch, jump2sub, retFsub, rp,
    output rl, empty, full, count, overflow, underflow
  );
endinterface

// File: rtl/return_stack.sv
// Hardware call/return address stack; supplies the program counter's return link.
// Circular storage: pushing while full overwrites the oldest entry.
module return_stack #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          start,
  return_stack_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] top_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;
  logic          unf_q;

  logic          push_c;
  logic          pop_c;
  logic          is_empty_c;
  logic          is_full_c;
  logic [PW-1:0] top_inc_c;
  logic [AW-1:0] ret_addr_c;

  // Same priority as the program counter: branch > call > return.
  assign push_c     = bus.jump2sub & ~bus.branch;
  assign pop_c      = bus.retFsub & ~bus.branch & ~bus.jump2sub;
  assign is_empty_c = (count_q == CW'(0));
  assign is_full_c  = (count_q == CW'(DEPTH));
  assign top_inc_c  = top_q + PW'(1);
  assign ret_addr_c = bus.rp + AW'(1);

  // Pointer, occupancy and sticky error flags.
  always_ff @(posedge clk) begin
    if (start) begin
      top_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (push_c) begin
      top_q <= top_inc_c;
      if (is_full_c) begin
        ovf_q <= 1'b1;
      end else begin
        count_q <= count_q + CW'(1);
      end
    end else if (pop_c) begin
      if (is_empty_c) begin
        unf_q <= 1'b1;
      end else begin
        top_q   <= top_q - PW'(1);
        count_q <= count_q - CW'(1);
      end
    end
  end

  // Entry storage needs no reset; only valid entries are ever presented.
  always_ff @(posedge clk) begin
    if (!start && push_c) begin
      mem[top_inc_c] <= ret_addr_c;
    end
  end

  // Zero-latency read so the program counter can load rl on the pop edge.
  assign bus.rl        = is_empty_c ? '0 : mem[top_q];
  assign bus.empty     = is_empty_c;
  assign bus.full      = is_full_c;
  assign bus.count     = count_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule

// File: tb/tb_return_stack.sv
// Scoreboard bench for return_stack: a model stack of expected return links is
// filled on calls and drained/compared when the design presents rl on returns.
module tb_return_stack;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 10;

  logic clk = 1'b0;
  logic start;

  return_stack_if #(.DEPTH(DEPTH), .AW(AW)) bus ();

  return_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .start (start),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [AW-1:0] exp_q[$];
  logic          exp_ovf;
  logic          exp_unf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [AW-1:0] exp_rl;
    exp_rl = (exp_q.size() > 0) ? exp_q[$] : '0;
    check({tag, ".count"},     32'(bus.count),     32'(exp_q.size()));
    check({tag, ".empty"},     32'(bus.empty),     32'(exp_q.size() == 0));
    check({tag, ".full"},      32'(bus.full),      32'(exp_q.size() == DEPTH));
    check({tag, ".rl"},        32'(bus.rl),        32'(exp_rl));
    check({tag, ".overflow"},  32'(bus.overflow),  32'(exp_ovf));
    check({tag, ".underflow"}, 32'(bus.underflow), 32'(exp_unf));
  endtask

  task automatic do_reset(input logic with_call, input string tag);
    @(negedge clk);
    start        = 1'b1;
    bus.branch   = 1'b0;
    bus.jump2sub = with_call;
    bus.retFsub  = 1'b0;
    bus.rp       = 10'h123;
    @(posedge clk);
    #1;
    start        = 1'b0;
    bus.jump2sub = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    check_state(tag);
  endtask

  // One decoder cycle; return link is checked before the edge, state after it.
  task automatic op(input logic b, input logic j, input logic r,
                    input logic [AW-1:0] a, input string tag);
    logic          push;
    logic          pop;
    logic [AW-1:0] exp_rl;
    @(negedge clk);
    bus.branch   = b;
    bus.jump2sub = j;
    bus.retFsub  = r;
    bus.rp       = a;
    push = j & ~b;
    pop  = r & ~b & ~j;
    if (pop) begin
      if (exp_q.size() > 0) begin
        exp_rl = exp_q.pop_back();
      end else begin
        exp_rl  = '0;
        exp_unf = 1'b1;
      end
      #1;
      check({tag, ".pop_rl"}, 32'(bus.rl), 32'(exp_rl));
    end
    if (push) begin
      if (exp_q.size() == DEPTH) begin
        void'(exp_q.pop_front());
        exp_ovf = 1'b1;
      end
      exp_q.push_back(a + AW'(1));
    end
    @(posedge clk);
    #1;
    bus.branch   = 1'b0;
    bus.jump2sub = 1'b0;
    bus.retFsub  = 1'b0;
    check_state(tag);
  endtask

  initial begin
    start        = 1'b0;
    bus.branch   = 1'b0;
    bus.jump2sub = 1'b0;
    bus.retFsub  = 1'b0;
    bus.rp       = '0;
    exp_ovf      = 1'b0;
    exp_unf      = 1'b0;

    do_reset(1'b0, "reset");

    // Reset mid-stack with a simultaneous call.
    op(1'b0, 1'b1, 1'b0, 10'h100, "pre_push0");
    op(1'b0, 1'b1, 1'b0, 10'h200, "pre_push1");
    op(1'b0, 1'b1, 1'b0, 10'h300, "pre_push2");
    do_reset(1'b1, "reset_mid");

    // Nested call/return.
    op(1'b0, 1'b1, 1'b0, 10'h010, "nest_push0");
    op(1'b0, 1'b1, 1'b0, 10'h020, "nest_push1");
    op(1'b0, 1'b1, 1'b0, 10'h030, "nest_push2");
    for (int i = 0; i < 3; i++) op(1'b0, 1'b0, 1'b1, 10'h000, $sformatf("nest_pop%0d", i));

    // Address wrap and strobe priority.
    op(1'b0, 1'b1, 1'b0, 10'h3FF, "wrap_push");
    op(1'b1, 1'b1, 1'b0, 10'h155, "branch_block");
    op(1'b1, 1'b0, 1'b1, 10'h155, "branch_block_pop");
    op(1'b0, 1'b0, 1'b0, 10'h155, "idle");
    op(1'b0, 1'b1, 1'b1, 10'h100, "call_over_ret");
    op(1'b0, 1'b0, 1'b1, 10'h000, "prio_pop0");
    op(1'b0, 1'b0, 1'b1, 10'h000, "prio_pop1");

    // Overflow: nine calls into an eight-deep stack.
    do_reset(1'b0, "reset_ovf");
    for (int i = 0; i < 9; i++) op(1'b0, 1'b1, 1'b0, AW'(i), $sformatf("ovf_push%0d", i));
    for (int i = 0; i < 8; i++) op(1'b0, 1'b0, 1'b1, 10'h000, $sformatf("ovf_pop%0d", i));

    // Underflow, then a call; the flag stays sticky until reset.
    op(1'b0, 1'b0, 1'b1, 10'h000, "unf_pop");
    op(1'b0, 1'b1, 1'b0, 10'h050, "unf_push");
    op(1'b0, 1'b0, 1'b0, 10'h000, "unf_hold");
    do_reset(1'b0, "reset_final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
